// File: rtl/mem_ctrl_pkg.sv
// Shared widths, FSM state encoding and command record for the memory access controller.
package mem_ctrl_pkg;

  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 8;
  localparam int PHASE_W   = 3;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } mem_ctrl_state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Phase lengths must fit the 3-bit phase counter and be at least one cycle.
  function automatic bit phase_in_range(input int n);
    return (n >= 1) && (n <= (1 << PHASE_W) - 1);
  endfunction

endpackage

// File: rtl/mem_access_controller_if.sv
// Command/response handshake plus the memory pin bundle of the access controller.
interface mem_access_controller_if;
  import mem_ctrl_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_data;

  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_op;
  logic              mem_select;
  logic [DATA_W-1:0] mem_dout;

  logic              busy;
  logic              init_done;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, mem_dout,
    output cmd_ready, rsp_valid, rsp_write, rsp_data,
    output mem_adr, mem_din, mem_op, mem_select, busy, init_done
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, mem_dout,
    input  cmd_ready, rsp_valid, rsp_write, rsp_data,
    input  mem_adr, mem_din, mem_op, mem_select, busy, init_done
  );

endinterface

// File: rtl/mem_phase_timer.sv
// Loadable down-counter timing the SETUP and STROBE phases; done marks a phase's last cycle.
module mem_phase_timer
  import mem_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  output logic               done
);

  logic [PHASE_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == PHASE_W'(1));

endmodule

// File: rtl/mem_access_controller.sv
// Sequences read/write commands onto the 8x8 memory pins with setup/strobe/hold phases,
// optionally clearing every word after reset before accepting traffic.
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int                SETUP_CYCLES  = 1,
  parameter int                STROBE_CYCLES = 2,
  parameter int                INIT_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE    = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mem_access_controller_if.slave   bus
);

  localparam logic [PHASE_W-1:0] SETUP_LOAD      = PHASE_W'(SETUP_CYCLES);
  localparam logic [PHASE_W-1:0] STROBE_LOAD     = PHASE_W'(STROBE_CYCLES);
  localparam mem_ctrl_state_t    RESET_STATE     = (INIT_ON_RESET != 0) ? INIT : IDLE;
  localparam logic               INIT_DONE_RESET = (INIT_ON_RESET == 0);
  localparam logic [ADDR_W-1:0]  LAST_ADDR       = ADDR_W'(MEM_DEPTH - 1);

  if (!phase_in_range(SETUP_CYCLES)) begin : g_bad_setup
    $error("mem_access_controller: SETUP_CYCLES must be 1..7");
  end
  if (!phase_in_range(STROBE_CYCLES)) begin : g_bad_strobe
    $error("mem_access_controller: STROBE_CYCLES must be 1..7");
  end
  if (INIT_ON_RESET != 0 && INIT_ON_RESET != 1) begin : g_bad_init
    $error("mem_access_controller: INIT_ON_RESET must be 0 or 1");
  end

  mem_ctrl_state_t    state_reg;
  mem_ctrl_state_t    state_next;
  mem_cmd_t           cmd_reg;
  logic               rsp_write_reg;
  logic [DATA_W-1:0]  rsp_data_reg;
  logic [ADDR_W-1:0]  init_addr_reg;
  logic               init_done_reg;

  logic               timer_load;
  logic [PHASE_W-1:0] timer_val;
  logic               timer_done;
  logic               accept;

  assign accept = (state_reg == IDLE) && bus.cmd_valid;

  mem_phase_timer u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RESET_STATE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The timer is loaded on the edge that enters a timed phase, so its count
  // reaches 1 exactly in that phase's final cycle.
  always_comb begin
    state_next = state_reg;
    timer_load = 1'b0;
    timer_val  = SETUP_LOAD;
    case (state_reg)
      INIT: begin
        state_next = SETUP;
        timer_load = 1'b1;
      end
      IDLE: begin
        if (bus.cmd_valid) begin
          state_next = SETUP;
          timer_load = 1'b1;
        end
      end
      SETUP: begin
        if (timer_done) begin
          state_next = STROBE;
          timer_load = 1'b1;
          timer_val  = STROBE_LOAD;
        end
      end
      STROBE: begin
        if (timer_done) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!init_done_reg) begin
          state_next = (init_addr_reg == LAST_ADDR) ? IDLE : INIT;
        end else begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_reg       <= '0;
      rsp_write_reg <= 1'b0;
      rsp_data_reg  <= '0;
      init_addr_reg <= '0;
      init_done_reg <= INIT_DONE_RESET;
    end else begin
      if (state_reg == INIT) begin
        cmd_reg.write <= 1'b1;
        cmd_reg.addr  <= init_addr_reg;
        cmd_reg.wdata <= INIT_VALUE;
      end
      if (accept) begin
        cmd_reg.write <= bus.cmd_write;
        cmd_reg.addr  <= bus.cmd_addr;
        cmd_reg.wdata <= bus.cmd_write ? bus.cmd_wdata : '0;
        rsp_write_reg <= bus.cmd_write;
        rsp_data_reg  <= '0;
      end
      // Read data is taken while select is still high, on the last strobe edge.
      if (state_reg == STROBE && timer_done && !cmd_reg.write) begin
        rsp_data_reg <= bus.mem_dout;
      end
      if (state_reg == HOLD && !init_done_reg) begin
        init_addr_reg <= init_addr_reg + 1'b1;
        if (init_addr_reg == LAST_ADDR) begin
          init_done_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.cmd_ready  = (state_reg == IDLE);
  assign bus.rsp_valid  = (state_reg == RESP);
  assign bus.rsp_write  = rsp_write_reg;
  assign bus.rsp_data   = rsp_data_reg;
  assign bus.mem_adr    = cmd_reg.addr;
  assign bus.mem_din    = cmd_reg.wdata;
  assign bus.mem_op     = cmd_reg.write;
  assign bus.mem_select = (state_reg == STROBE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.init_done  = init_done_reg;

endmodule

// File: tb/tb_mem_access_controller.sv
// Randomized bench for two controller configurations (1/2 and 3/1 phase cycles), each
// attached to its own 8-word memory model and checked against a reference memory image.
module tb_mem_access_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n;
  logic [1:0] cmd_valid;
  logic [1:0] cmd_write;
  logic [1:0] rsp_ready;
  logic [2:0] cmd_addr  [2];
  logic [7:0] cmd_wdata [2];

  logic [1:0] cmd_ready;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_write;
  logic [1:0] mem_op;
  logic [1:0] mem_select;
  logic [1:0] busy;
  logic [1:0] init_done;
  logic [7:0] rsp_data [2];
  logic [7:0] mem_din  [2];
  logic [2:0] mem_adr  [2];

  int n_cmp = 0;
  int n_err = 0;

  int         setup_c  [2] = '{1, 3};
  int         strobe_c [2] = '{2, 1};
  logic [7:0] init_v   [2] = '{8'h00, 8'h5A};
  logic [7:0] ref_mem  [2][8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int         SC  = (gi == 0) ? 1 : 3;
    localparam int         STC = (gi == 0) ? 2 : 1;
    localparam logic [7:0] IV  = (gi == 0) ? 8'h00 : 8'h5A;

    mem_access_controller_if bus_if ();

    mem_access_controller #(
      .SETUP_CYCLES  (SC),
      .STROBE_CYCLES (STC),
      .INIT_ON_RESET (1),
      .INIT_VALUE    (IV)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n[gi]),
      .bus   (bus_if)
    );

    assign bus_if.cmd_valid = cmd_valid[gi];
    assign bus_if.cmd_write = cmd_write[gi];
    assign bus_if.cmd_addr  = cmd_addr[gi];
    assign bus_if.cmd_wdata = cmd_wdata[gi];
    assign bus_if.rsp_ready = rsp_ready[gi];

    assign cmd_ready[gi]  = bus_if.cmd_ready;
    assign rsp_valid[gi]  = bus_if.rsp_valid;
    assign rsp_write[gi]  = bus_if.rsp_write;
    assign rsp_data[gi]   = bus_if.rsp_data;
    assign mem_adr[gi]    = bus_if.mem_adr;
    assign mem_din[gi]    = bus_if.mem_din;
    assign mem_op[gi]     = bus_if.mem_op;
    assign mem_select[gi] = bus_if.mem_select;
    assign busy[gi]       = bus_if.busy;
    assign init_done[gi]  = bus_if.init_done;

    // Memory model: writes while selected, drives its word while selected.
    logic [7:0] mem_q [8];
    always @(posedge clk) begin
      if (bus_if.mem_select && bus_if.mem_op) mem_q[bus_if.mem_adr] <= bus_if.mem_din;
    end
    assign bus_if.mem_dout = bus_if.mem_select ? mem_q[bus_if.mem_adr] : 8'h00;

    // Address/data/op must hold from select high through the following cycle.
    logic       sel_p;
    logic [2:0] adr_p;
    logic [7:0] din_p;
    logic       op_p;
    always @(negedge clk) begin
      if (sel_p && rst_n[gi]) begin
        check("stable_pins", 32'({bus_if.mem_op, bus_if.mem_adr, bus_if.mem_din}),
              32'({op_p, adr_p, din_p}));
      end
      sel_p <= bus_if.mem_select;
      adr_p <= bus_if.mem_adr;
      din_p <= bus_if.mem_din;
      op_p  <= bus_if.mem_op;
    end
  end

  task automatic do_reset(input int u);
    rst_n[u]     = 1'b0;
    cmd_valid[u] = 1'b0;
    rsp_ready[u] = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid[u]), 32'd0);
    check("rst_select", 32'(mem_select[u]), 32'd0);
    check("rst_adr", 32'(mem_adr[u]), 32'd0);
    check("rst_din", 32'(mem_din[u]), 32'd0);
    check("rst_op", 32'(mem_op[u]), 32'd0);
    check("rst_rsp_data", 32'(rsp_data[u]), 32'd0);
    check("rst_rsp_write", 32'(rsp_write[u]), 32'd0);
    check("rst_init_done", 32'(init_done[u]), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready[u]), 32'd0);
    rst_n[u] = 1'b1;
  endtask

  task automatic check_init(input int u);
    int pulses = 0;
    bit seen_rdy = 0;
    bit prev_sel = 0;
    bit done = 0;
    // A pending command must be ignored for the whole sweep.
    cmd_valid[u] = 1'b1;
    cmd_write[u] = 1'b1;
    cmd_addr[u]  = 3'($urandom);
    cmd_wdata[u] = 8'($urandom);
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (init_done[u]) begin
        done = 1;
      end else begin
        if (cmd_ready[u]) seen_rdy = 1;
        if (mem_select[u] && !prev_sel) begin
          check("init_adr", 32'(mem_adr[u]), 32'(pulses));
          check("init_din", 32'(mem_din[u]), 32'(init_v[u]));
          check("init_op", 32'(mem_op[u]), 32'd1);
          pulses++;
        end
        prev_sel = mem_select[u];
      end
    end
    cmd_valid[u] = 1'b0;
    check("init_done", 32'(done), 32'd1);
    check("init_pulses", 32'(pulses), 32'd8);
    check("init_no_ready", 32'(seen_rdy), 32'd0);
    check("init_idle_ready", 32'(cmd_ready[u]), 32'd1);
    for (int i = 0; i < 8; i++) ref_mem[u][i] = init_v[u];
    $display("txn dut%0d init sweep pulses=%0d value=%02h", u, pulses, init_v[u]);
  endtask

  task automatic run_cmd(input int u, input bit wr, input logic [2:0] a,
                         input logic [7:0] d, input int stall);
    int         k;
    int         lat;
    int         sel_lo;
    int         sel_hi;
    logic [7:0] exp_data;
    lat      = setup_c[u] + strobe_c[u] + 2;
    sel_lo   = setup_c[u] + 1;
    sel_hi   = setup_c[u] + strobe_c[u];
    exp_data = wr ? 8'h00 : ref_mem[u][a];

    cmd_valid[u] = 1'b1;
    cmd_write[u] = wr;
    cmd_addr[u]  = a;
    cmd_wdata[u] = d;
    for (int c = 0; c < 20 && !cmd_ready[u]; c++) @(negedge clk);
    check("acc_ready", 32'(cmd_ready[u]), 32'd1);
    @(negedge clk);
    cmd_valid[u] = 1'b0;
    cmd_addr[u]  = 3'($urandom);
    cmd_wdata[u] = 8'($urandom);
    check("acc_adr", 32'(mem_adr[u]), 32'(a));
    check("acc_din", 32'(mem_din[u]), 32'(wr ? d : 8'h00));
    check("acc_op", 32'(mem_op[u]), 32'(wr));
    check("acc_busy", 32'(busy[u]), 32'd1);
    check("acc_not_ready", 32'(cmd_ready[u]), 32'd0);

    k = 1;
    while (!rsp_valid[u] && k < lat + 4) begin
      check("sel_window", 32'(mem_select[u]), 32'(k >= sel_lo && k <= sel_hi));
      rsp_ready[u] = 1'($urandom_range(0, 1));
      @(negedge clk);
      k++;
    end
    check("rsp_latency", 32'(k), 32'(lat));

    rsp_ready[u] = 1'b0;
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", 32'(rsp_valid[u]), 32'd1);
      check("stall_data", 32'(rsp_data[u]), 32'(exp_data));
      check("stall_write", 32'(rsp_write[u]), 32'(wr));
      check("stall_not_ready", 32'(cmd_ready[u]), 32'd0);
      cmd_valid[u] = 1'($urandom_range(0, 1));
      cmd_write[u] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("rsp_valid", 32'(rsp_valid[u]), 32'd1);
    check("rsp_data", 32'(rsp_data[u]), 32'(exp_data));
    check("rsp_write", 32'(rsp_write[u]), 32'(wr));
    cmd_valid[u] = 1'b0;
    rsp_ready[u] = 1'b1;
    @(negedge clk);
    rsp_ready[u] = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid[u]), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready[u]), 32'd1);
    check("post_busy", 32'(busy[u]), 32'd0);

    if (wr) ref_mem[u][a] = d;
    $display("txn dut%0d %s a=%0d d=%02h rsp=%02h stall=%0d", u, wr ? "WR" : "RD", a,
             wr ? d : exp_data, rsp_data[u], stall);
  endtask

  task automatic reset_in_strobe(input int u);
    cmd_valid[u] = 1'b1;
    cmd_write[u] = 1'b1;
    cmd_addr[u]  = 3'd5;
    cmd_wdata[u] = 8'h77;
    for (int c = 0; c < 20 && !cmd_ready[u]; c++) @(negedge clk);
    @(negedge clk);
    cmd_valid[u] = 1'b0;
    for (int c = 0; c < 10 && !mem_select[u]; c++) @(negedge clk);
    check("abort_in_strobe", 32'(mem_select[u]), 32'd1);
    #1 rst_n[u] = 1'b0;
    #1;
    check("abort_select", 32'(mem_select[u]), 32'd0);
    check("abort_adr", 32'(mem_adr[u]), 32'd0);
    check("abort_din", 32'(mem_din[u]), 32'd0);
    check("abort_op", 32'(mem_op[u]), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid[u]), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready[u]), 32'd0);
    check("abort_init_done", 32'(init_done[u]), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_rsp", 32'(rsp_valid[u]), 32'd0);
    rst_n[u] = 1'b1;
    $display("txn dut%0d WR a=5 aborted by reset", u);
    check_init(u);
  endtask

  initial begin
    rst_n     = 2'b00;
    cmd_valid = 2'b00;
    cmd_write = 2'b00;
    rsp_ready = 2'b00;
    for (int u = 0; u < 2; u++) begin
      cmd_addr[u]  = 3'd0;
      cmd_wdata[u] = 8'h00;
    end
    for (int u = 0; u < 2; u++) begin
      do_reset(u);
      check_init(u);
      run_cmd(u, 1'b1, 3'd3, 8'hA5, 0);
      run_cmd(u, 1'b0, 3'd3, 8'h00, 0);
      run_cmd(u, 1'b0, 3'd3, 8'h00, 4);
      run_cmd(u, 1'b0, 3'd6, 8'h00, 1);
      for (int n = 0; n < 25; n++) begin
        run_cmd(u, 1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)));
      end
      if (u == 0) begin
        reset_in_strobe(u);
        run_cmd(u, 1'b0, 3'd5, 8'h00, 0);
        run_cmd(u, 1'b1, 3'd5, 8'h3C, 2);
        run_cmd(u, 1'b0, 3'd5, 8'h00, 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
